// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol assembler.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap
    } state_t;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    function automatic int len_width(input int max_syms);
        return $clog2(max_syms + 1);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus saturating unit counter; clr restarts both and overrides a coincident wrap.
module morse_unit_timer #(
    parameter int unsigned UNIT_TICKS = 4_999_999,
    parameter int unsigned CNT_BITS   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    output logic [CNT_BITS-1:0] units
);

    localparam int unsigned PW = (UNIT_TICKS > 0) ? $clog2(UNIT_TICKS + 1) : 1;

    logic [PW-1:0]       presc_q, presc_d;
    logic [CNT_BITS-1:0] units_q, units_d;
    logic                wrap;

    assign wrap  = (presc_q == PW'(UNIT_TICKS));
    assign units = units_q;

    always_comb begin
        presc_d = presc_q + PW'(1);
        units_d = units_q;
        if (clr) begin
            presc_d = '0;
            units_d = '0;
        end else if (wrap) begin
            presc_d = '0;
            if (units_q != '1) begin
                units_d = units_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_symbol_assembler.sv
// Times key presses/gaps and assembles dot/dash elements into a character code.
// Define MORSE_SYNC_EN to add a 2-flop input synchroniser on b.
module morse_symbol_assembler
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_TICKS = 4_999_999,
    parameter int unsigned CNT_BITS   = 4,
    parameter int unsigned DOT_MAX    = 2,
    parameter int unsigned DASH_MAX   = 4,
    parameter int unsigned LG_UNITS   = 3,
    parameter int unsigned WG_UNITS   = 7,
    parameter int unsigned MAX_SYMS   = 6
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             b,
    output logic                             dot,
    output logic                             dash,
    output logic                             lg,
    output logic                             wg,
    output logic                             char_valid,
    output logic [MAX_SYMS-1:0]              code,
    output logic [len_width(MAX_SYMS)-1:0]   len,
    output logic                             err
);

    localparam int LW = len_width(MAX_SYMS);
    localparam logic [CNT_BITS-1:0] DOT_C  = CNT_BITS'(DOT_MAX);
    localparam logic [CNT_BITS-1:0] DASH_C = CNT_BITS'(DASH_MAX);
    localparam logic [CNT_BITS-1:0] LG_C   = CNT_BITS'(LG_UNITS);
    localparam logic [CNT_BITS-1:0] WG_C   = CNT_BITS'(WG_UNITS);
    localparam logic [LW-1:0]       FULL_C = LW'(MAX_SYMS);

    logic b_s, b_d;
    logic rise, fall;
    logic [CNT_BITS-1:0] units;

`ifdef MORSE_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], b};
    end
    assign b_s = sync_q[1];
`else
    assign b_s = b;
`endif

    // b_d resets high so a key already held (or released) across reset never reads as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) b_d <= 1'b1;
        else          b_d <= b_s;
    end

    assign rise = b_s & ~b_d;
    assign fall = ~b_s & b_d;

    morse_unit_timer #(
        .UNIT_TICKS (UNIT_TICKS),
        .CNT_BITS   (CNT_BITS)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rise | fall),
        .units   (units)
    );

    state_t              state_q, state_d;
    logic [MAX_SYMS-1:0] buf_q, buf_d;
    logic [LW-1:0]       blen_q, blen_d;
    logic [MAX_SYMS-1:0] code_q;
    logic [LW-1:0]       len_q;
    logic dot_q, dash_q, err_q, lg_q, wg_q, cv_q;
    logic dot_d, dash_d, err_d, lg_d, wg_d;

    logic u_zero, u_dot, u_long, full, lg_hit, wg_hit, accept;

    assign u_zero = (units == '0);
    assign u_dot  = (units <= DOT_C);
    assign u_long = (units > DASH_C);
    assign full   = (blen_q == FULL_C);
    assign accept = (state_q == StPress) && fall && !u_zero && !u_long && !full;
    // An empty buffer in GAP means the letter gap has already been reported.
    assign lg_hit = (state_q == StGap) && (blen_q != '0) && (units >= LG_C);
    assign wg_hit = (state_q == StGap) && !rise && (units >= WG_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            buf_q   <= '0;
            blen_q  <= '0;
            code_q  <= '0;
            len_q   <= '0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            err_q   <= 1'b0;
            lg_q    <= 1'b0;
            wg_q    <= 1'b0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            blen_q  <= blen_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            err_q   <= err_d;
            lg_q    <= lg_d;
            wg_q    <= wg_d;
            cv_q    <= lg_d;
            if (lg_d) begin
                code_q <= buf_q;
                len_q  <= blen_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        blen_d  = blen_q;
        case (state_q)
            StIdle: begin
                if (rise) state_d = StPress;
            end
            StPress: begin
                if (fall) begin
                    if (u_zero) begin
                        state_d = (blen_q == '0) ? StIdle : StGap;
                    end else if (u_long || full) begin
                        state_d = StIdle;
                        buf_d   = '0;
                        blen_d  = '0;
                    end else begin
                        buf_d[blen_q] = u_dot ? ELEM_DOT : ELEM_DASH;
                        blen_d        = blen_q + LW'(1);
                        state_d       = StGap;
                    end
                end
            end
            StGap: begin
                if (lg_hit) begin
                    buf_d  = '0;
                    blen_d = '0;
                end
                if (rise)        state_d = StPress;
                else if (wg_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dot_d  = accept && u_dot;
        dash_d = accept && !u_dot;
        err_d  = (state_q == StPress) && fall && !u_zero && (u_long || full);
        lg_d   = lg_hit;
        wg_d   = wg_hit;
    end

    assign dot        = dot_q;
    assign dash       = dash_q;
    assign err        = err_q;
    assign lg         = lg_q;
    assign wg         = wg_q;
    assign char_valid = cv_q;
    assign code       = code_q;
    assign len        = len_q;

endmodule

// File: doc/morse_symbol_assembler.md
Name: morse_symbol_assembler

Overview:
Parametrised Morse front end: times key presses and gaps in configurable time units. Classifies each press as dot or dash, and each gap as an intra-character, letter or word gap. Assembles elements into a character code with length, and flags timing and overflow errors. Sits between the debounced key input and the character lookup/display logic.

Parameters:
UNIT_TICKS, 4_999_999, clock cycles per time unit minus 1 (50 ms at 100 MHz)
CNT_BITS, 4, width of saturating unit counter
DOT_MAX, 2, longest press (units) classified as dot; 1..DOT_MAX = dot
DASH_MAX, 4, longest valid press; DOT_MAX+1..DASH_MAX = dash
LG_UNITS, 3, key-up units that end a character
WG_UNITS, 7, key-up units that end a word; must exceed LG_UNITS, must be < 2^CNT_BITS
MAX_SYMS, 6, max elements per character

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
b  in  1  debounced key, 1 = pressed
dot  out  1  one-cycle pulse: dot accepted
dash  out  1  one-cycle pulse: dash accepted
lg  out  1  one-cycle pulse: letter gap detected
wg  out  1  one-cycle pulse: word gap detected
char_valid  out  1  one-cycle pulse: code/len updated
code  out  MAX_SYMS  element bits, bit i = element i (first element in bit 0), 1 = dash, unused bits 0
len  out  $clog2(MAX_SYMS+1)  element count of code
err  out  1  one-cycle pulse: over-long press or element overflow

Behaviour:
- Reset: all outputs 0, state IDLE, buffer/len cleared, timer cleared; takes effect immediately, mid-press or mid-gap included.
- b registered once into b_d. Edge = b != b_d. On the edge cycle, the prescaler and unit counter clear.
- Otherwise the prescaler counts 0..UNIT_TICKS. Each wrap increments the unit counter, which saturates at 2^CNT_BITS-1.
- Classification uses the unit count held before the edge cycle. A wrap coinciding with the edge is discarded.
- States: IDLE (no character in progress), PRESS, GAP.
- IDLE:
  - rise -> PRESS.
- PRESS, on fall:
  - units 0 -> glitch, no pulse, return to prior state (IDLE if buffer empty, else GAP).
  - 1..DOT_MAX -> dot pulse.
  - DOT_MAX+1..DASH_MAX -> dash pulse.
  - dot/dash append: bit len of buffer = element, len+1; -> GAP.
  - units > DASH_MAX -> err pulse, buffer/len cleared, -> IDLE.
  - element arriving when len == MAX_SYMS -> err pulse, no dot/dash pulse, buffer cleared, -> IDLE.
- Pulse timing: dot/dash/err are asserted the cycle after the edge cycle.
- GAP:
  - rise before LG_UNITS -> PRESS, same character.
  - units reach LG_UNITS -> lg and char_valid pulse together; code/len register the buffer; buffer cleared; stay in GAP (word timing continues).
  - units reach WG_UNITS -> wg pulse once -> IDLE.
  - rise between LG_UNITS and WG_UNITS -> PRESS, new character, no wg.
- code/len hold their value until the next char_valid; they are not cleared by err.
- Held key beyond saturation: still err on release. Held gap: exactly one lg and one wg.

Optional Feature:
MORSE_SYNC_EN:
- Defined: b passes through a 2-flop synchroniser before b_d; all pulse latencies +2 cycles.
- Undefined: b must already be synchronous to clk; no extra flops.

Decomposition:
- Package morse_pkg: state enum (IDLE, PRESS, GAP), ELEM_DOT = 0 / ELEM_DASH = 1 constants, len-width function.
- Sub-module morse_unit_timer: prescaler + saturating unit counter with synchronous clear; outputs unit count.

Test Plan (UNIT_TICKS=9, defaults otherwise):
1. b high 15 cycles, then low -> dot 1 cycle after release edge; 30 cycles later lg + char_valid with code=000000, len=1; at 70 cycles wg.
2. b high 35 cycles -> dash; after letter gap, code=000001, len=1.
3. "A": press 12, low 12, press 33, low 80 -> dot, dash, char_valid code=000010 len=2, one lg, one wg.
4. b high 5 cycles -> no dot/dash/err; state unchanged.
5. b high 60 cycles -> err only; no char_valid follows. Separately: 7 dots 12-cycle spaced -> err on 7th, no char_valid.
6. reset_n low mid-press (b high 25) -> all outputs 0 at once; release after reset gives no pulse.
